voice_sequencer: RTL and testbench
==================================

Name: voice_sequencer

Overview:
- Per-sample scheduler that runs up to N_VOICES instrument voices one after another on a single output sample.
- Shares one multiplier and one divider between the voices: only the currently selected voice drives the shared operands, and results are broadcast to all voices.
- Mixes the voice outputs with a saturating sum into one 24-bit sample.
- Sits between the sample-rate tick generator and the instrument bank; its finish pulse feeds the output DAC path.

Parameters:
- N_VOICES, 4, number of voice slots (1..16).
- WIDTH, 24, sample width, signed.
- TIMEOUT_CYCLES, 1023, per-voice cycle budget; used only with VOICE_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  sample tick, one-cycle pulse.
- finish  out  1  one-cycle pulse when mix_out is updated.
- busy  out  1  high whenever state != IDLE.
- overrun  out  1  sticky: a tick arrived while busy; cleared only by rst.
- voice_en  in  N_VOICES  voice enable mask, sampled on the accepted tick.
- voice_start  out  N_VOICES  one-hot start pulse to a voice.
- voice_finish  in  N_VOICES  finish pulses from the voices.
- voice_wave  in  N_VOICES x WIDTH  voice outputs, signed.
- voice_mult_a, voice_mult_b  in  N_VOICES x 32  per-voice multiplier operands.
- voice_div_n, voice_div_d  in  N_VOICES x 48  per-voice divider operands.
- mult_a, mult_b  out  32  operands to the shared multiplier.
- div_n, div_d  out  48  operands to the shared divider.
- mix_out  out  WIDTH  saturated mix, signed.
- timeout  out  1  sticky, VOICE_TIMEOUT_EN only, else tied 0.

Behaviour:
- Reset values:
  - state IDLE.
  - finish, busy, overrun, timeout, voice_start = 0.
  - mix_out = 0, acc = 0, idx = 0, en_q = 0.
  - mult_*/div_* = 0 (not X), so reset state is deterministic.
- States: IDLE, LAUNCH, RUN, DONE.
- IDLE:
  - On start: latch en_q = voice_en and clear acc.
  - If en_q is all zero, go to DONE with mix_out = 0.
  - Otherwise set idx = lowest enabled voice and go to LAUNCH.
- LAUNCH:
  - voice_start[idx] = 1 for exactly this cycle; next state RUN.
- RUN:
  - Wait for voice_finish[idx].
  - On that cycle: acc += sign-extended voice_wave[idx].
  - If a higher enabled voice exists, idx = that voice and go to LAUNCH; otherwise register mix_out = sat(acc + wave) and go to DONE.
  - voice_finish bits other than idx are ignored.
- DONE:
  - finish = 1 for one cycle, with mix_out already valid; next state IDLE.
- Operand muxing:
  - In LAUNCH and RUN, mult_a/mult_b/div_n/div_d combinationally follow voice idx.
  - In IDLE and DONE they are 0.
  - mult_p and div_q are wired to every voice outside this block.
- Accumulator: width WIDTH + clog2(N_VOICES), signed. Saturation clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Latency:
  - Tick at cycle T gives LAUNCH at T+1.
  - Each voice costs 1 + its run length in cycles, plus 1 DONE cycle.
  - All voices disabled: finish at T+2.
- Tick while busy, including the DONE cycle: the tick is dropped and overrun is set; the current sequence continues unaffected.
- rst mid-sequence returns to IDLE immediately. Voices are reset by the same rst.

Optional Feature:
- Macro: VOICE_TIMEOUT_EN.
- With the macro:
  - A counter runs during RUN and is cleared in LAUNCH.
  - If it reaches TIMEOUT_CYCLES without voice_finish[idx], the voice contributes 0, timeout is set (sticky), and the sequence advances as if the voice had finished.
  - A late finish from that voice is ignored.
- Without the macro: RUN waits indefinitely, timeout is tied 0, and the counter is not instantiated.

Decomposition:
- Package voice_seq_pkg:
  - state enum.
  - ACC_W function.
  - SAT_MAX / SAT_MIN constants for a given width.
- Sub-module voice_pick (combinational):
  - Inputs: en_q, idx, first flag.
  - Outputs: next enabled index above idx (or lowest if first) and a found flag.
  - Used in both IDLE and RUN.

Test Plan:
1. voice_en=4'b1111; voices return waves 100, -50, 7, 0, each after 5 cycles -> start pulses in order 0,1,2,3; mix_out=57; one finish pulse; finish at T+1+4*6+1.
2. voice_en=4'b1010 -> only voice_start[1] then voice_start[3] fire; during each RUN, mult_a equals that voice's voice_mult_a (e.g. 0xAAAA0001, 0xAAAA0003); voices 0 and 2 never started.
3. Four voices each 0x7FFFFF -> mix_out=0x7FFFFF; four voices each 0x800000 -> mix_out=0x800000.
4. voice_en=0 -> finish at T+2, mix_out=0, no voice_start asserted.
5. Second tick 3 cycles after first, and another tick in the DONE cycle -> overrun=1, exactly one finish, mix unchanged; overrun stays 1 until rst; rst in RUN -> busy=0 the next cycle.
6. With VOICE_TIMEOUT_EN and TIMEOUT_CYCLES=8, voice 1 never finishes -> timeout=1, voice 1 contributes 0, voice 2 starts after 8 RUN cycles, finish still produced.

Source files
------------

// File: rtl/voice_seq_pkg.sv
// voice_seq_pkg: shared types and helpers for the voice sequencer.
// Optional VOICE_TIMEOUT_EN handling lives in voice_sequencer.sv.
package voice_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    RUN,
    DONE
  } state_t;

  function automatic int ACC_W(input int width, input int n);
    return width + $clog2(n);
  endfunction

  function automatic longint SAT_MAX(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  function automatic longint SAT_MIN(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/voice_pick.sv
// voice_pick: finds the next enabled voice above idx,
// or the lowest enabled voice when first is set.
module voice_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  en_q,
  input  logic [IW-1:0] idx,
  input  logic          first,
  output logic [IW-1:0] next,
  output logic          found
);

  // descending scan so the lowest qualifying voice wins
  always_comb begin
    next  = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (en_q[i] && (first || IW'(i) > idx)) begin
        next  = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/voice_sequencer.sv
// voice_sequencer: runs enabled voices in turn per sample tick
// and mixes them with saturation. Option: VOICE_TIMEOUT_EN.
module voice_sequencer
  import voice_seq_pkg::*;
#(
  parameter int N_VOICES       = 4,
  parameter int WIDTH          = 24,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  output logic                               finish,
  output logic                               busy,
  output logic                               overrun,
  input  logic [N_VOICES-1:0]                voice_en,
  output logic [N_VOICES-1:0]                voice_start,
  input  logic [N_VOICES-1:0]                voice_finish,
  input  logic [N_VOICES-1:0][WIDTH-1:0]     voice_wave,
  input  logic [N_VOICES-1:0][31:0]          voice_mult_a,
  input  logic [N_VOICES-1:0][31:0]          voice_mult_b,
  input  logic [N_VOICES-1:0][47:0]          voice_div_n,
  input  logic [N_VOICES-1:0][47:0]          voice_div_d,
  output logic [31:0]                        mult_a,
  output logic [31:0]                        mult_b,
  output logic [47:0]                        div_n,
  output logic [47:0]                        div_d,
  output logic [WIDTH-1:0]                   mix_out,
  output logic                               timeout
);

  localparam int IW = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
  localparam int AW = ACC_W(WIDTH, N_VOICES);
  localparam logic signed [AW-1:0] HI = AW'(SAT_MAX(WIDTH));
  localparam logic signed [AW-1:0] LO = AW'(SAT_MIN(WIDTH));

  if (N_VOICES < 1 || N_VOICES > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("voice_sequencer: bad parameters");
  end

  state_t state, state_n;

  logic [N_VOICES-1:0]     en_q;
  logic [IW-1:0]           idx;
  logic signed [AW-1:0]    acc;
  logic signed [AW-1:0]    sum;
  logic signed [WIDTH-1:0] wave;
  logic [WIDTH-1:0]        sat_val;
  logic [N_VOICES-1:0]     mask;
  logic [IW-1:0]           pick;
  logic                    found;
  logic                    hit;
  logic                    adv;

  assign mask = (state == IDLE) ? voice_en : en_q;
  assign busy = (state != IDLE);
  assign hit  = voice_finish[idx];

  voice_pick #(
    .N  (N_VOICES),
    .IW (IW)
  ) u_pick (
    .en_q  (mask),
    .idx   (idx),
    .first (state == IDLE),
    .next  (pick),
    .found (found)
  );

`ifdef VOICE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          expired;

  assign expired = (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign adv     = hit | expired;
  // a timed-out voice adds nothing to the mix
  assign wave    = hit ? voice_wave[idx] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      if (state == LAUNCH)
        cnt <= '0;
      else if (state == RUN && !expired)
        cnt <= cnt + 1'b1;
      if (state == RUN && expired && !hit)
        timeout <= 1'b1;
    end
  end
`else
  assign adv     = hit;
  assign wave    = voice_wave[idx];
  assign timeout = 1'b0;
`endif

  assign sum = acc + AW'(wave);

  always_comb begin
    if (sum > HI)
      sat_val = HI[WIDTH-1:0];
    else if (sum < LO)
      sat_val = LO[WIDTH-1:0];
    else
      sat_val = sum[WIDTH-1:0];
  end

  always_comb begin
    state_n     = state;
    voice_start = '0;
    mult_a      = '0;
    mult_b      = '0;
    div_n       = '0;
    div_d       = '0;
    unique case (state)
      IDLE: begin
        if (start)
          state_n = found ? LAUNCH : DONE;
      end
      LAUNCH: begin
        voice_start[idx] = 1'b1;
        mult_a  = voice_mult_a[idx];
        mult_b  = voice_mult_b[idx];
        div_n   = voice_div_n[idx];
        div_d   = voice_div_d[idx];
        state_n = RUN;
      end
      RUN: begin
        mult_a = voice_mult_a[idx];
        mult_b = voice_mult_b[idx];
        div_n  = voice_div_n[idx];
        div_d  = voice_div_d[idx];
        if (adv)
          state_n = found ? LAUNCH : DONE;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      finish  <= 1'b0;
      overrun <= 1'b0;
      mix_out <= '0;
      acc     <= '0;
      idx     <= '0;
      en_q    <= '0;
    end else begin
      state  <= state_n;
      finish <= (state == DONE);
      if (start && state != IDLE)
        overrun <= 1'b1;
      if (state == IDLE && start) begin
        en_q <= voice_en;
        acc  <= '0;
        idx  <= pick;
        if (!found)
          mix_out <= '0;
      end
      if (state == RUN && adv) begin
        acc <= sum;
        if (found)
          idx <= pick;
        else
          mix_out <= sat_val;
      end
    end
  end

endmodule

// File: tb/tb_voice_sequencer.sv
// tb_voice_sequencer: table vectors, random sequences and hand
// corner cases against a behavioural mixing/latency model.
module tb_voice_sequencer;

  localparam int NV = 4;
  localparam int W  = 24;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic                finish;
  logic                busy;
  logic                overrun;
  logic [NV-1:0]       voice_en;
  logic [NV-1:0]       voice_start;
  logic [NV-1:0]       voice_finish;
  logic [NV-1:0][W-1:0] wave_cfg;
  logic [NV-1:0][31:0] voice_mult_a;
  logic [NV-1:0][31:0] voice_mult_b;
  logic [NV-1:0][47:0] voice_div_n;
  logic [NV-1:0][47:0] voice_div_d;
  logic [31:0]         mult_a;
  logic [31:0]         mult_b;
  logic [47:0]         div_n;
  logic [47:0]         div_d;
  logic [W-1:0]        mix_out;
  logic                timeout;

  voice_sequencer #(
    .N_VOICES       (NV),
    .WIDTH          (W),
    .TIMEOUT_CYCLES (1023)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .finish       (finish),
    .busy         (busy),
    .overrun      (overrun),
    .voice_en     (voice_en),
    .voice_start  (voice_start),
    .voice_finish (voice_finish),
    .voice_wave   (wave_cfg),
    .voice_mult_a (voice_mult_a),
    .voice_mult_b (voice_mult_b),
    .voice_div_n  (voice_div_n),
    .voice_div_d  (voice_div_d),
    .mult_a       (mult_a),
    .mult_b       (mult_b),
    .div_n        (div_n),
    .div_d        (div_d),
    .mix_out      (mix_out),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // voice models: finish d cycles after the launch cycle
  int dly [NV];
  int vcnt [NV];
  always @(posedge clk) begin
    for (int k = 0; k < NV; k++) begin
      if (rst) vcnt[k] <= 0;
      else if (voice_start[k]) vcnt[k] <= dly[k];
      else if (vcnt[k] > 0) vcnt[k] <= vcnt[k] - 1;
    end
  end
  always_comb begin
    voice_finish = '0;
    for (int k = 0; k < NV; k++) voice_finish[k] = (vcnt[k] == 1);
  end

  typedef struct {
    int          idx;
    logic [31:0] ma;
    logic [31:0] mb;
    logic [47:0] dn;
    logic [47:0] dd;
  } launch_t;

  launch_t launches[$];
  int      fin_cnt = 0;

  always @(negedge clk) begin
    launch_t e;
    if (|voice_start) begin
      e.idx = $onehot(voice_start) ? 0 : -1;
      for (int k = 0; k < NV; k++)
        if (voice_start[k] && e.idx == 0) e.idx = k;
      e.ma = mult_a;
      e.mb = mult_b;
      e.dn = div_n;
      e.dd = div_d;
      launches.push_back(e);
    end
  end
  always @(posedge clk) if (finish) fin_cnt <= fin_cnt + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [W-1:0] mix_model(input logic [NV-1:0] en);
    longint s = 0;
    for (int k = 0; k < NV; k++)
      if (en[k]) s += longint'(signed'(wave_cfg[k]));
    if (s > 8388607) s = 8388607;
    if (s < -8388608) s = -8388608;
    return W'(s);
  endfunction

  function automatic int lat_model(input logic [NV-1:0] en);
    int l = 2;
    for (int k = 0; k < NV; k++)
      if (en[k]) l += 1 + dly[k];
    return l;
  endfunction

  task automatic refresh_ops();
    for (int k = 0; k < NV; k++) begin
      voice_mult_a[k] = 32'hAAAA0000 | 32'(k);
      voice_mult_b[k] = $urandom;
      voice_div_n[k]  = (48'($urandom) << 16) ^ 48'($urandom);
      voice_div_d[k]  = (48'($urandom) << 16) ^ 48'($urandom);
    end
  endtask

  task automatic check_launches(input logic [NV-1:0] en, input int base);
    int exp_idx[$];
    int got;
    for (int k = 0; k < NV; k++) if (en[k]) exp_idx.push_back(k);
    got = launches.size() - base;
    chk("launch_count", 64'(got), 64'(exp_idx.size()));
    for (int i = 0; i < exp_idx.size() && i < got; i++) begin
      chk("launch_idx", 64'(launches[base+i].idx), 64'(exp_idx[i]));
      chk("mult_a", 64'(launches[base+i].ma), 64'(voice_mult_a[exp_idx[i]]));
      chk("mult_b", 64'(launches[base+i].mb), 64'(voice_mult_b[exp_idx[i]]));
      chk("div_n", 64'(launches[base+i].dn), 64'(voice_div_n[exp_idx[i]]));
      chk("div_d", 64'(launches[base+i].dd), 64'(voice_div_d[exp_idx[i]]));
    end
  endtask

  task automatic run_seq(input logic [NV-1:0] en, input logic [W-1:0] emix,
                         input int elat);
    int t0, lb, fb;
    voice_en = en;
    lb = launches.size();
    @(negedge clk);
    fb = fin_cnt;
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    while (!finish && cyc < t0 + 200) @(negedge clk);
    if (!finish) chk("finish_timeout", 64'(0), 64'(1));
    else begin
      chk("latency", 64'(cyc - t0), 64'(elat));
      chk("mix_out", 64'(mix_out), 64'(emix));
    end
    repeat (3) @(negedge clk);
    chk("finish_pulses", 64'(fin_cnt - fb), 64'(1));
    chk("idle_mult_a", 64'(mult_a), 64'(0));
    check_launches(en, lb);
  endtask

  typedef struct {
    logic [NV-1:0]        en;
    logic [NV-1:0][W-1:0] w;
    logic [W-1:0]         mix;
    int                   lat;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int t0, lb, fb;
    tbl[0] = '{4'b1111, {24'd0, 24'd7, 24'hFFFFCE, 24'd100}, 24'd57, 26};
    tbl[1] = '{4'b1010, {24'd40, 24'd30, 24'd20, 24'd10}, 24'd60, 14};
    tbl[2] = '{4'b1111, {4{24'h7FFFFF}}, 24'h7FFFFF, 26};
    tbl[3] = '{4'b1111, {4{24'h800000}}, 24'h800000, 26};
    tbl[4] = '{4'b0000, {4{24'h123456}}, 24'd0, 2};
    tbl[5] = '{4'b0001, {24'd5, 24'd5, 24'd5, 24'hFFFFFF}, 24'hFFFFFF, 8};
    tbl[6] = '{4'b1100, {24'h7FFFFF, 24'd1, 24'd9, 24'd9}, 24'h7FFFFF, 14};

    rst = 1'b1;
    start = 1'b0;
    voice_en = '0;
    wave_cfg = '0;
    for (int k = 0; k < NV; k++) dly[k] = 5;
    refresh_ops();
    repeat (3) @(negedge clk);
    chk("rst_finish", 64'(finish), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_overrun", 64'(overrun), 64'(0));
    chk("rst_vstart", 64'(voice_start), 64'(0));
    chk("rst_mix", 64'(mix_out), 64'(0));
    chk("rst_ops", 64'(mult_a) | 64'(mult_b) | 64'(div_n) | 64'(div_d), 64'(0));
    chk("rst_timeout", 64'(timeout), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      wave_cfg = tbl[i].w;
      run_seq(tbl[i].en, tbl[i].mix, tbl[i].lat);
    end

    for (int it = 0; it < 25; it++) begin
      for (int k = 0; k < NV; k++) begin
        case ($urandom_range(0, 3))
          0: wave_cfg[k] = 24'h7FFFFF;
          1: wave_cfg[k] = 24'h800000;
          default: wave_cfg[k] = W'($urandom);
        endcase
        dly[k] = $urandom_range(1, 6);
      end
      refresh_ops();
      voice_en = NV'($urandom);
      run_seq(voice_en, mix_model(voice_en), lat_model(voice_en));
    end
    chk("no_overrun_yet", 64'(overrun), 64'(0));

    // ticks 3 cycles in and during DONE are dropped
    wave_cfg = tbl[0].w;
    for (int k = 0; k < NV; k++) dly[k] = 5;
    voice_en = 4'b1111;
    lb = launches.size();
    @(negedge clk);
    fb = fin_cnt;
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + 25) @(negedge clk);
    chk("done_busy", 64'(busy), 64'(1));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ovr_finish", 64'(finish), 64'(1));
    chk("ovr_mix", 64'(mix_out), 64'(mix_model(4'b1111)));
    repeat (4) @(negedge clk);
    chk("ovr_pulses", 64'(fin_cnt - fb), 64'(1));
    chk("ovr_idle", 64'(busy), 64'(0));
    chk("overrun_set", 64'(overrun), 64'(1));
    check_launches(4'b1111, lb);

    wave_cfg = tbl[1].w;
    run_seq(4'b1010, 24'd60, 14);
    chk("overrun_sticky", 64'(overrun), 64'(1));

    // reset in the middle of RUN
    voice_en = 4'b0110;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", 64'(busy), 64'(0));
    chk("rst_mid_overrun", 64'(overrun), 64'(0));
    chk("rst_mid_ops", 64'(mult_a), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    run_seq(4'b0110, mix_model(4'b0110), lat_model(4'b0110));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
